// File: rtl/layer_sequencer_if.sv
// Memory-side bus of the layer sequencer: activation read (proc1), result write (proc2)
// and weight fetch. The sequencer uses the master modport, the caches/weight store the slave.
interface layer_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] proc1_Addr;
  logic              proc1_WE;
  logic [DATA_W-1:0] proc1_DataOut;
  logic [ADDR_W-1:0] proc2_Addr;
  logic [DATA_W-1:0] proc2_DataIn;
  logic              proc2_WE;
  logic [ADDR_W-1:0] weight_Addr;
  logic [DATA_W-1:0] weight_Data;

  modport master (
    output proc1_Addr, proc1_WE, proc2_Addr, proc2_DataIn, proc2_WE, weight_Addr,
    input  proc1_DataOut, weight_Data
  );

  modport slave (
    input  proc1_Addr, proc1_WE, proc2_Addr, proc2_DataIn, proc2_WE, weight_Addr,
    output proc1_DataOut, weight_Data
  );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks every neuron of every layer, accumulating a fixed-point dot product
// and ping-ponging the caches. Define LAYER_SEQ_RELU_EN to clamp negative results to zero.
module layer_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   numIn,
  input  logic [ADDR_W-1:0]   numOut,
  input  logic [7:0]          numLayers,
  layer_sequencer_if.master   bus,
  output logic                cacheSecond,
  output logic                critical,
  output logic                busy,
  output logic                done,
  output logic [7:0]          layerIdx
);

  localparam int unsigned ProdW = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StWrite,
    StSwap,
    StDone
  } state_e;

  state_e                    r_state;
  logic [ADDR_W-1:0]         r_num_in;
  logic [ADDR_W-1:0]         r_num_out;
  logic [7:0]                r_num_layers;
  logic [ADDR_W-1:0]         r_i;
  logic [ADDR_W-1:0]         r_j;
  logic [ADDR_W-1:0]         r_waddr;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_pend;
  logic [DATA_W-1:0]         r_wdata;
  logic                      r_cache_second;
  logic [7:0]                r_layer;

  logic signed [ProdW-1:0]   w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic signed [ACC_W-1:0]   w_shifted;
  logic [DATA_W-1:0]         w_sat;
  logic [DATA_W-1:0]         w_result;
  logic [ADDR_W-1:0]         w_j_next;
  logic [7:0]                w_layer_next;

  // Product of the pair whose addresses were issued last cycle.
  assign w_prod       = $signed(bus.proc1_DataOut) * $signed(bus.weight_Data);
  assign w_prod_ext   = {{(ACC_W - ProdW){w_prod[ProdW-1]}}, w_prod};
  assign w_acc_sum    = r_acc + w_prod_ext;
  assign w_shifted    = w_acc_sum >>> FRAC;
  assign w_j_next     = r_j + {{(ADDR_W - 1){1'b0}}, 1'b1};
  assign w_layer_next = r_layer + 8'd1;

  always_comb begin
    w_sat = w_shifted[DATA_W-1:0];
    if (w_shifted > SatMax) begin
      w_sat = SatMax[DATA_W-1:0];
    end else if (w_shifted < SatMin) begin
      w_sat = SatMin[DATA_W-1:0];
    end
  end

`ifdef LAYER_SEQ_RELU_EN
  assign w_result = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_num_in       <= '0;
      r_num_out      <= '0;
      r_num_layers   <= '0;
      r_i            <= '0;
      r_j            <= '0;
      r_waddr        <= '0;
      r_acc          <= '0;
      r_pend         <= 1'b0;
      r_wdata        <= '0;
      r_cache_second <= 1'b0;
      r_layer        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_num_in     <= numIn;
            r_num_out    <= numOut;
            r_num_layers <= numLayers;
            r_i          <= '0;
            r_j          <= '0;
            r_waddr      <= '0;
            r_acc        <= '0;
            r_pend       <= 1'b0;
            r_wdata      <= '0;
            r_layer      <= '0;
            if (numLayers == 8'd0) begin
              r_state <= StDone;
            end else if (numOut == '0) begin
              r_state <= StSwap;
            end else if (numIn == '0) begin
              r_state <= StWrite;
            end else begin
              r_state <= StFetch;
            end
          end
        end

        StFetch: begin
          if (r_pend) begin
            r_acc <= w_acc_sum;
          end
          r_pend  <= 1'b1;
          r_i     <= r_i + {{(ADDR_W - 1){1'b0}}, 1'b1};
          r_waddr <= r_waddr + {{(ADDR_W - 1){1'b0}}, 1'b1};
          if (r_i == r_num_in - {{(ADDR_W - 1){1'b0}}, 1'b1}) begin
            r_state <= StDrain;
          end
        end

        StDrain: begin
          r_wdata <= w_result;
          r_pend  <= 1'b0;
          r_state <= StWrite;
        end

        StWrite: begin
          // Cleared so a following zero-input neuron writes 0.
          r_wdata <= '0;
          r_acc   <= '0;
          r_i     <= '0;
          r_j     <= w_j_next;
          if (w_j_next == r_num_out) begin
            r_state <= StSwap;
          end else if (r_num_in == '0) begin
            r_state <= StWrite;
          end else begin
            r_state <= StFetch;
          end
        end

        StSwap: begin
          r_cache_second <= ~r_cache_second;
          r_layer        <= w_layer_next;
          r_j            <= '0;
          if (w_layer_next == r_num_layers) begin
            r_state <= StDone;
          end else if (r_num_out == '0) begin
            r_state <= StSwap;
          end else if (r_num_in == '0) begin
            r_state <= StWrite;
          end else begin
            r_state <= StFetch;
          end
        end

        StDone: begin
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.proc1_Addr   = r_i;
  assign bus.proc1_WE     = 1'b0;
  assign bus.weight_Addr  = r_waddr;
  assign bus.proc2_Addr   = r_j;
  assign bus.proc2_DataIn = r_wdata;
  assign bus.proc2_WE     = (r_state == StWrite);

  assign busy        = (r_state != StIdle) && (r_state != StDone);
  assign critical    = busy;
  assign done        = (r_state == StDone);
  assign cacheSecond = r_cache_second;
  assign layerIdx    = r_layer;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed runs with expected writes queued up front and
// compared by an independent write monitor.
module tb_layer_sequencer;
  localparam int DW = 16;
  localparam int AW = 16;

`ifdef LAYER_SEQ_RELU_EN
  localparam logic [15:0] ExpNegSat = 16'h0000;
  localparam logic [15:0] ExpL1N1   = 16'h0000;
`else
  localparam logic [15:0] ExpNegSat = 16'h8000;
  localparam logic [15:0] ExpL1N1   = 16'hFD00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] numIn = '0;
  logic [15:0] numOut = '0;
  logic [7:0]  numLayers = '0;
  logic        cacheSecond, critical, busy, done;
  logic [7:0]  layerIdx;

  layer_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  layer_sequencer #(.DATA_W(DW), .ADDR_W(AW), .FRAC(8), .ACC_W(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .numIn      (numIn),
    .numOut     (numOut),
    .numLayers  (numLayers),
    .bus        (bus),
    .cacheSecond(cacheSecond),
    .critical   (critical),
    .busy       (busy),
    .done       (done),
    .layerIdx   (layerIdx)
  );

  always #5 clk = ~clk;

  logic [15:0] act_mem [16];
  logic [15:0] w_mem   [64];
  logic [15:0] act_rd = '0;
  logic [15:0] w_rd   = '0;

  always @(posedge clk) begin
    act_rd <= act_mem[bus.proc1_Addr[3:0]];
    w_rd   <= w_mem[bus.weight_Addr[5:0]];
  end
  assign bus.proc1_DataOut = act_rd;
  assign bus.weight_Data   = w_rd;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_cs   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 16; k++) act_mem[k] = '0;
    for (int k = 0; k < 64; k++) w_mem[k] = '0;
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.proc2_WE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'h0, bus.proc2_Addr, bus.proc2_DataIn}, 64'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", bus.proc2_Addr, e.addr);
        check("write_data", bus.proc2_DataIn, e.data);
        check("write_busy", {busy, critical}, 2'b11);
      end
    end
  end

  task automatic run(input int nin, input int nout, input int nl, input int exp_cycles,
                     input bit mid_start);
    int cyc;
    bit got;
    bit busy_drop;
    cyc = 0;
    got = 1'b0;
    busy_drop = 1'b0;
    numIn = 16'(nin);
    numOut = 16'(nout);
    numLayers = 8'(nl);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else if (!busy || !critical) busy_drop = 1'b1;
      if (mid_start && cyc == 3) begin
        numIn = 16'd1;
        numLayers = 8'd5;
        start = 1'b1;
      end
      if (mid_start && cyc == 4) start = 1'b0;
    end
    exp_cs ^= nl[0];
    check("done_seen", got, 1'b1);
    check("done_latency", cyc, exp_cycles);
    check("busy_held", busy_drop, 1'b0);
    check("busy_at_done", {busy, critical}, 2'b00);
    check("layer_idx", layerIdx, nl);
    check("weight_addr", bus.weight_Addr, 16'(nl * nout * nin));
    check("cache_second", cacheSecond, exp_cs);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {bus.proc1_Addr, bus.proc2_Addr, bus.proc2_DataIn, bus.weight_Addr},
          64'h0);
    check("reset_flags",
          {bus.proc1_WE, bus.proc2_WE, cacheSecond, critical, busy, done, layerIdx},
          14'h0);

    // Single neuron: 1.0*1.5 + 2.0*0.5 = 2.5
    act_mem[0] = 16'h0100; act_mem[1] = 16'h0200;
    w_mem[0]   = 16'h0180; w_mem[1]   = 16'h0080;
    exp_q.push_back('{addr: 16'd0, data: 16'h0280});
    run(2, 1, 1, 6, 1'b0);

    // Abort during FETCH: cacheSecond was 1 and must return to 0.
    numIn = 16'd2; numOut = 16'd1; numLayers = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("abort_pre_busy", {busy, cacheSecond}, 2'b11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_state", {bus.proc2_WE, busy, critical, cacheSecond}, 4'b0000);
    exp_cs = 1'b0;
    repeat (8) @(negedge clk);

    // Two layers of two neurons; a second start mid-run must be ignored.
    clear_mem();
    act_mem[0] = 16'h0100; act_mem[1] = 16'h0200; act_mem[2] = 16'hFF00;
    w_mem[0] = 16'h0100; w_mem[1] = 16'h0100; w_mem[2]  = 16'h0100;
    w_mem[3] = 16'h0080; w_mem[4] = 16'h0080; w_mem[5]  = 16'h0000;
    w_mem[6] = 16'h0200; w_mem[7] = 16'h0000; w_mem[8]  = 16'h0100;
    w_mem[9] = 16'h0000; w_mem[10] = 16'h0000; w_mem[11] = 16'h0300;
    exp_q.push_back('{addr: 16'd0, data: 16'h0200});
    exp_q.push_back('{addr: 16'd1, data: 16'h0180});
    exp_q.push_back('{addr: 16'd0, data: 16'h0100});
    exp_q.push_back('{addr: 16'd1, data: ExpL1N1});
    run(3, 2, 2, 23, 1'b1);

    // No inputs: two zero writes back to back.
    exp_q.push_back('{addr: 16'd0, data: 16'h0000});
    exp_q.push_back('{addr: 16'd1, data: 16'h0000});
    run(0, 2, 1, 4, 1'b0);

    // Zero layers: done the cycle after start, nothing written.
    run(2, 2, 0, 1, 1'b0);

    // Positive and negative saturation.
    clear_mem();
    act_mem[0] = 16'h7FFF; w_mem[0] = 16'h7FFF;
    exp_q.push_back('{addr: 16'd0, data: 16'h7FFF});
    run(1, 1, 1, 5, 1'b0);
    act_mem[0] = 16'h8000;
    exp_q.push_back('{addr: 16'd0, data: ExpNegSat});
    run(1, 1, 1, 5, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Upstream control stage for the layer router. Drives the proc1 port (read previous-layer activations) and the proc2 port (write current-layer results), plus cacheSecond and critical.
- Walks every neuron of every layer and computes a fixed-point weighted sum of the inputs against an external weight memory.
- Toggles cacheSecond between layers so the two caches ping-pong as input and output buffers.
- Holds critical high while running so the user port is locked out.

Parameters:
- DATA_W, 16, activation/weight width (signed two's complement).
- ADDR_W, 16, cache and weight address width.
- FRAC, 8, fractional bits; the product sum is arithmetic-shifted right by FRAC before saturation.
- ACC_W, 40, accumulator width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- numIn  in  ADDR_W  inputs per neuron; sampled at start.
- numOut  in  ADDR_W  neurons per layer; sampled at start.
- numLayers  in  8  layers to run; sampled at start.
- proc1_Addr  out  ADDR_W  input-activation read address.
- proc1_WE  out  1  constant 0.
- proc1_DataOut  in  DATA_W  activation read data, valid 1 cycle after address.
- proc2_Addr  out  ADDR_W  result write address.
- proc2_DataIn  out  DATA_W  result data.
- proc2_WE  out  1  result write strobe.
- weight_Addr  out  ADDR_W  weight memory address.
- weight_Data  in  DATA_W  weight, valid 1 cycle after address.
- cacheSecond  out  1  ping-pong select to the router.
- critical  out  1  high while busy.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- layerIdx  out  8  current layer number.

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator 0.
  - Reset mid-run aborts at once. No further proc2_WE. cacheSecond returns to 0.
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, FETCH, DRAIN, WRITE, SWAP, DONE.
- IDLE
  - start=1 latches numIn, numOut and numLayers. It clears layerIdx, neuron counter j, input counter i, weight_Addr and the accumulator.
  - Next state is FETCH. If numLayers==0, next state is DONE.
  - start while busy is ignored.
- FETCH
  - Each cycle: proc1_Addr=i, weight_Addr=running weight counter. Both counters increment.
  - Each cycle in which the previous address pair is valid: acc += proc1_DataOut*weight_Data (signed, sign-extended to ACC_W).
  - After issuing i=numIn-1, go to DRAIN.
- DRAIN
  - One cycle: accumulates the last product.
- WRITE
  - One cycle: proc2_Addr=j, proc2_WE=1, proc2_DataIn=sat(acc>>>FRAC).
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Then acc=0, i=0, j++.
  - If j reached numOut, go to SWAP; otherwise go to FETCH.
- numIn==0: skip FETCH and DRAIN. The neuron writes 0.
- numOut==0: the layer writes nothing and goes straight to SWAP.
- SWAP
  - cacheSecond toggles, layerIdx++, j=0.
  - If layerIdx reached numLayers, go to DONE; otherwise go to FETCH.
  - weight_Addr keeps counting across layers; it is not reset between layers.
- DONE
  - done=1 for one cycle; busy and critical drop the same cycle; next state is IDLE.
- cacheSecond persists across runs, toggling once per completed layer. The final results therefore sit in the cache selected by the final cacheSecond.
- busy = critical = (state != IDLE and state != DONE).
- Latency per neuron: numIn+2 cycles (numIn FETCH, 1 DRAIN, 1 WRITE). Per layer: numOut*(numIn+2)+1 cycles.
- Counters wrap modulo 2^ADDR_W. No overflow detection.

Optional Feature:
- Macro: LAYER_SEQ_RELU_EN.
- Defined: the WRITE value is max(0, sat(acc>>>FRAC)), i.e. negative results are written as 0.
- Undefined: the signed saturated value is written unmodified.

Test Plan:
- Reset checks:
  - Reset then idle: all outputs 0 and cacheSecond=0.
  - Assert rst during FETCH of layer 0: next cycle proc2_WE=0, busy=0, cacheSecond=0.
- Single neuron, FRAC=8, numIn=2, numOut=1, numLayers=1:
  - Stimulus: activations 0x0100, 0x0200; weights 0x0180, 0x0080.
  - proc2_WE pulses once, proc2_Addr=0, proc2_DataIn=0x0280.
  - cacheSecond ends 1; done pulses 6 cycles after start.
- Saturation, numIn=1: activation 0x7FFF, weight 0x7FFF → proc2_DataIn=0x7FFF. Activation 0x8000, weight 0x7FFF → 0x8000 (without RELU_EN) or 0x0000 (with RELU_EN).
- Multi-layer, numIn=3, numOut=2, numLayers=2:
  - 4 writes total; proc2_Addr sequence 0,1,0,1.
  - weight_Addr reaches 11 (0..11, 12 reads).
  - cacheSecond toggles 0→1→0; layerIdx 0→1→2.
  - critical high throughout; done pulses once.
- Edge cases:
  - numIn=0, numOut=2, numLayers=1: two writes of 0 on consecutive WRITE cycles.
  - numLayers=0: done pulses the cycle after start; no writes; cacheSecond unchanged.
  - start pulsed again mid-run: ignored.
